// File: rtl/runner_ctrl.sv
// runner_ctrl - parametrised runner character controller.
//
// Sits between input/collision logic and the renderer. Every state change
// happens only on a cycle where `update` is high (one frame tick). All
// outputs are registered, so they reflect a tick one clock after it.
//
// Handshake: `update` is a one-cycle strobe with no back-pressure. A cycle
// with update=1 is consumed unconditionally. A cycle with update=0 changes
// nothing, and jump/duck/crash are ignored on that cycle.
//
// Optional feature macro: RUNNER_RESTART_EN
//   defined   : a jump press in CRASHED restarts the runner in RUNNING.
//   undefined : CRASHED is left only through rst.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   update              frame tick strobe
//   timer [5:0]         frame counter 0..59, selects animation frames
//   speed [4:0]         game speed, raises the launch velocity (speed>>3)
//   jump, duck, crash   level inputs
//   x_pos, y_pos        signed top-left position (POS_W bits)
//   width, height       current sprite size
//   state [2:0]         WAITING=0 RUNNING=1 JUMPING=2 DROPPING=3 DUCKING=4 CRASHED=5
//   frame [2:0]         sprite frame, WAITING0..CRASHED0 = 0..7
//   jumps_used [1:0]    launches made in the current airborne period

module runner_ctrl #(
  parameter int POS_W          = 12,
  parameter int START_X        = 20,
  parameter int GROUND_Y       = 93,
  parameter int INIT_VEL       = -10,
  parameter int GRAVITY        = 6,
  parameter int GRAV_DEN       = 10,
  parameter int DROP_VEL       = -5,
  parameter int MIN_JUMP_H     = 30,
  parameter int SPEED_DROP_VEL = 1,
  parameter int DROP_COEF      = 3,
  parameter int MAX_JUMPS      = 2,
  parameter int WIDTH          = 44,
  parameter int WIDTH_DUCK     = 59,
  parameter int HEIGHT         = 47
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    update,
  input  logic [5:0]              timer,
  input  logic [4:0]              speed,
  input  logic                    jump,
  input  logic                    duck,
  input  logic                    crash,
  output logic signed [POS_W-1:0] x_pos,
  output logic signed [POS_W-1:0] y_pos,
  output logic [9:0]              width,
  output logic [9:0]              height,
  output logic [2:0]              state,
  output logic [2:0]              frame,
  output logic [1:0]              jumps_used
);

  typedef enum logic [2:0] {
    WAITING  = 3'd0,
    RUNNING  = 3'd1,
    JUMPING  = 3'd2,
    DROPPING = 3'd3,
    DUCKING  = 3'd4,
    CRASHED  = 3'd5
  } state_t;

  localparam logic [2:0] F_WAITING0 = 3'd0;
  localparam logic [2:0] F_WAITING1 = 3'd1;
  localparam logic [2:0] F_RUNNING0 = 3'd2;
  localparam logic [2:0] F_RUNNING1 = 3'd3;
  localparam logic [2:0] F_JUMPING0 = 3'd4;
  localparam logic [2:0] F_DUCKING0 = 3'd5;
  localparam logic [2:0] F_DUCKING1 = 3'd6;
  localparam logic [2:0] F_CRASHED0 = 3'd7;

  // Extended width for position arithmetic so that y + nv*k cannot wrap.
  localparam int EW = POS_W + 4;

  localparam logic signed [POS_W-1:0] START_XP  = POS_W'(START_X);
  localparam logic signed [POS_W-1:0] GROUND_YP = POS_W'(GROUND_Y);
  localparam logic signed [EW-1:0]    GROUND_E  = EW'(GROUND_Y);
  localparam logic signed [EW-1:0]    MIN_H_E   = EW'(GROUND_Y - MIN_JUMP_H);
  localparam logic signed [EW-1:0]    COEF_E    = EW'(DROP_COEF);
  localparam logic signed [7:0]       DROP_V8   = 8'(DROP_VEL);
  localparam logic [5:0]              GRAV6     = 6'(GRAVITY);
  localparam logic [5:0]              DEN6      = 6'(GRAV_DEN);

  // Registered state
  state_t             state_q;
  logic signed [7:0]  vel;
  logic [4:0]         acc;
  logic               jump_q;
  logic               min_reached;

  // Next-state values
  state_t             state_d;
  logic signed [POS_W-1:0] x_d, y_d;
  logic signed [7:0]  vel_d;
  logic [4:0]         acc_d;
  logic [1:0]         jumps_d;
  logic               min_d;

  // Physics step
  logic [5:0]         acc_sum;
  logic [4:0]         acc_n;
  logic signed [7:0]  nv;
  logic signed [7:0]  launch_vel;
  logic signed [EW-1:0] y_ext, nv_ext, step_ext, ny_ext;
  logic signed [POS_W-1:0] ny;
  logic               jump_rise;
  logic               landing;
  logic               below_min;
  logic               can_jump;

  assign jump_rise = jump & ~jump_q;
  assign can_jump  = 32'(jumps_used) < MAX_JUMPS;

  // Gravity is a fractional accumulator: velocity gains 1 each time the
  // accumulated GRAVITY reaches GRAV_DEN.
  always_comb begin
    acc_sum    = {1'b0, acc} + GRAV6;
    acc_n      = acc_sum[4:0];
    nv         = vel;
    if (acc_sum >= DEN6) begin
      acc_n = 5'(acc_sum - DEN6);
      nv    = vel + 8'sd1;
    end
    launch_vel = 8'(INIT_VEL) - 8'(speed >> 3);
    y_ext      = EW'(y_pos);
    nv_ext     = EW'(nv);
    step_ext   = (state_q == DROPPING) ? nv_ext * COEF_E : nv_ext;
    ny_ext     = y_ext + step_ext;
    ny         = ny_ext[POS_W-1:0];
    landing    = ny_ext >= GROUND_E;
    below_min  = ny_ext < MIN_H_E;
  end

  // Next-state logic; priority is crash, then landing, then player input.
  always_comb begin
    state_d = state_q;
    x_d     = x_pos;
    y_d     = y_pos;
    vel_d   = vel;
    acc_d   = acc;
    jumps_d = jumps_used;
    min_d   = min_reached;

    if (crash) begin
      state_d = CRASHED;
      // The ducking sprite is offset by one pixel relative to the crash sprite.
      if (state_q == DUCKING) x_d = x_pos + POS_W'(1);
    end else begin
      case (state_q)
        WAITING: begin
          if (jump_rise) state_d = RUNNING;
        end

        RUNNING: begin
          x_d     = START_XP;
          y_d     = GROUND_YP;
          vel_d   = '0;
          acc_d   = '0;
          jumps_d = '0;
          min_d   = 1'b0;
          if (jump_rise) begin
            state_d = JUMPING;
            y_d     = y_pos;
            vel_d   = launch_vel;
            jumps_d = jumps_used + 2'd1;
          end else if (duck) begin
            state_d = DUCKING;
          end
        end

        JUMPING: begin
          if (landing) begin
            state_d = RUNNING;
            y_d     = GROUND_YP;
            vel_d   = '0;
            acc_d   = '0;
            jumps_d = '0;
            min_d   = 1'b0;
          end else if (jump_rise && can_jump) begin
            y_d     = ny;
            vel_d   = launch_vel;
            acc_d   = '0;
            min_d   = 1'b0;
            jumps_d = jumps_used + 2'd1;
          end else if (duck) begin
            state_d = DROPPING;
            y_d     = ny;
            vel_d   = 8'(SPEED_DROP_VEL);
            acc_d   = '0;
            min_d   = 1'b1;
          end else begin
            y_d   = ny;
            vel_d = nv;
            acc_d = acc_n;
            min_d = min_reached | below_min;
            // Early release (or leaving the top of the screen) caps the
            // upward speed once the minimum height has been reached.
            if ((!jump || ny_ext < 0) && min_d && nv < DROP_V8)
              vel_d = DROP_V8;
          end
        end

        DROPPING: begin
          if (landing) begin
            state_d = RUNNING;
            y_d     = GROUND_YP;
            vel_d   = '0;
            acc_d   = '0;
            jumps_d = '0;
            min_d   = 1'b0;
          end else if (!duck) begin
            state_d = JUMPING;
          end else begin
            y_d   = ny;
            vel_d = nv;
            acc_d = acc_n;
          end
        end

        DUCKING: begin
          if (!duck) state_d = RUNNING;
        end

        CRASHED: begin
`ifdef RUNNER_RESTART_EN
          if (jump_rise) begin
            state_d = RUNNING;
            x_d     = START_XP;
            y_d     = GROUND_YP;
            vel_d   = '0;
            acc_d   = '0;
            jumps_d = '0;
            min_d   = 1'b0;
          end
`endif
        end

        default: state_d = WAITING;
      endcase
    end
  end

  function automatic logic [2:0] frame_for(input state_t s, input logic [5:0] t);
    logic [2:0] f;
    case (s)
      WAITING:          f = (t >= 6'd30) ? F_WAITING0 : F_WAITING1;
      RUNNING:          f = ((t % 6'd10) < 6'd5) ? F_RUNNING0 : F_RUNNING1;
      JUMPING,
      DROPPING:         f = F_JUMPING0;
      DUCKING:          f = ((t % 6'd20) < 6'd10) ? F_DUCKING0 : F_DUCKING1;
      default:          f = F_CRASHED0;
    endcase
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAITING;
      x_pos       <= START_XP;
      y_pos       <= GROUND_YP;
      vel         <= '0;
      acc         <= '0;
      jump_q      <= 1'b0;
      min_reached <= 1'b0;
      jumps_used  <= '0;
      frame       <= F_WAITING0;
      width       <= 10'(WIDTH);
    end else if (update) begin
      state_q     <= state_d;
      x_pos       <= x_d;
      y_pos       <= y_d;
      vel         <= vel_d;
      acc         <= acc_d;
      jump_q      <= jump;
      min_reached <= min_d;
      jumps_used  <= jumps_d;
      frame       <= frame_for(state_d, timer);
      width       <= (state_d == DUCKING) ? 10'(WIDTH_DUCK) : 10'(WIDTH);
    end
  end

  assign state  = state_q;
  assign height = 10'(HEIGHT);

endmodule

// File: tb/tb_runner_ctrl.sv
// tb_runner_ctrl - directed bench for runner_ctrl with default parameters.
// Walks a fixed scenario: reset, start, jump with double jump and capped
// release, landing, drop with clamped landing, duck, crash, and either
// restart (RUNNER_RESTART_EN) or a frozen crash, then a final reset.
// All expected values are hand-derived from the physics rules.

module tb_runner_ctrl;

  logic        clk;
  logic        rst;
  logic        update;
  logic [5:0]  timer;
  logic [4:0]  speed;
  logic        jump, duck, crash;
  logic signed [11:0] x_pos, y_pos;
  logic [9:0]  width, height;
  logic [2:0]  state, frame;
  logic [1:0]  jumps_used;

  int errors = 0;
  int checks = 0;
  logic landed;

  runner_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .update     (update),
    .timer      (timer),
    .speed      (speed),
    .jump       (jump),
    .duck       (duck),
    .crash      (crash),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .width      (width),
    .height     (height),
    .state      (state),
    .frame      (frame),
    .jumps_used (jumps_used)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one update tick; outputs are stable at the returning negedge.
  task automatic tick(input logic j, input logic d, input logic c,
                      input logic [5:0] t, input logic [4:0] sp);
    @(negedge clk);
    jump   = j;
    duck   = d;
    crash  = c;
    timer  = t;
    speed  = sp;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; update = 1'b0; timer = '0; speed = '0;
    jump = 1'b0; duck = 1'b0; crash = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Reset state
    check("rst_state", state, 0);
    check("rst_x", x_pos, 20);
    check("rst_y", y_pos, 93);
    check("rst_frame", frame, 0);
    check("rst_jumps", jumps_used, 0);
    check("rst_width", width, 44);
    check("rst_height", height, 47);

    // Waiting animation, then start
    tick(0, 0, 0, 10, 0);
    check("wait_frame1", frame, 1);
    tick(1, 0, 0, 40, 0);
    check("start_state", state, 1);
    check("start_frame", frame, 2);
    check("start_y", y_pos, 93);
    tick(0, 0, 0, 7, 0);
    check("run_frame1", frame, 3);

    // Launch at speed 0: vel=-10, y unchanged
    tick(1, 0, 0, 0, 0);
    check("launch_state", state, 2);
    check("launch_y", y_pos, 93);
    check("launch_jumps", jumps_used, 1);
    check("launch_frame", frame, 4);
    tick(1, 0, 0, 0, 0);
    check("jump_y1", y_pos, 83);
    tick(1, 0, 0, 0, 0);
    check("jump_y2", y_pos, 74);

    // update low: inputs including crash are ignored
    crash = 1'b1; jump = 1'b0; duck = 1'b1;
    idle(3);
    check("hold_state", state, 2);
    check("hold_y", y_pos, 74);

    // Release (acc 8, vel -9) then relaunch at speed 8 (vel -11)
    tick(0, 0, 0, 0, 0);
    check("release_y", y_pos, 65);
    tick(1, 0, 0, 0, 8);
    check("relaunch_y", y_pos, 57);
    check("relaunch_jumps", jumps_used, 2);
    // Release above min height: vel -11 capped to -5
    tick(0, 0, 0, 0, 0);
    check("cap_y", y_pos, 46);
    // Third press ignored: step from vel -5, acc 6 -> nv -4
    tick(1, 0, 0, 0, 0);
    check("third_press_y", y_pos, 42);
    check("third_press_jumps", jumps_used, 2);
    check("third_press_state", state, 2);

    // Fall back to the ground (bounded)
    landed = 1'b0;
    for (int i = 0; i < 60 && !landed; i++) begin
      tick(1, 0, 0, 20, 0);
      if (state == 3'd1) landed = 1'b1;
    end
    check("land1_seen", landed, 1);
    check("land1_y", y_pos, 93);
    check("land1_jumps", jumps_used, 0);

    // Second jump, then drop
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("jump2_jumps", jumps_used, 1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("jump2_y4", y_pos, 57);
    tick(1, 1, 0, 0, 0);
    check("drop_state", state, 3);
    check("drop_y", y_pos, 50);
    check("drop_frame", frame, 4);
    tick(1, 1, 0, 0, 0);
    check("drop_y1", y_pos, 53);
    tick(1, 1, 0, 0, 0);
    check("drop_y2", y_pos, 59);
    tick(1, 1, 0, 0, 0);
    check("drop_y3", y_pos, 65);
    tick(1, 1, 0, 0, 0);
    check("drop_y4", y_pos, 74);
    tick(1, 1, 0, 0, 0);
    check("drop_y5", y_pos, 86);
    // ny = 98 clamps to the ground line
    tick(1, 1, 0, 3, 0);
    check("land2_state", state, 1);
    check("land2_y", y_pos, 93);
    check("land2_jumps", jumps_used, 0);
    check("land2_frame", frame, 2);

    // Duck
    tick(0, 1, 0, 12, 0);
    check("duck_state", state, 4);
    check("duck_width", width, 59);
    check("duck_frame", frame, 6);

    // Crash with update low is ignored
    crash = 1'b1;
    idle(3);
    check("crash_hold_state", state, 4);
    check("crash_hold_x", x_pos, 20);

    // Crash from ducking
    tick(0, 1, 1, 12, 0);
    check("crash_state", state, 5);
    check("crash_x", x_pos, 21);
    check("crash_frame", frame, 7);
    check("crash_width", width, 44);
    check("crash_y", y_pos, 93);

`ifdef RUNNER_RESTART_EN
    tick(0, 0, 0, 7, 0);
    check("restart_wait_state", state, 5);
    tick(1, 0, 0, 7, 0);
    check("restart_state", state, 1);
    check("restart_x", x_pos, 20);
    check("restart_y", y_pos, 93);
    check("restart_frame", frame, 3);
    check("restart_jumps", jumps_used, 0);
`else
    tick(0, 0, 0, 7, 0);
    tick(1, 0, 0, 7, 0);
    check("terminal_state", state, 5);
    check("terminal_x", x_pos, 21);
    check("terminal_frame", frame, 7);
`endif

    // Final reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst2_state", state, 0);
    check("rst2_x", x_pos, 20);
    check("rst2_y", y_pos, 93);
    check("rst2_frame", frame, 0);
    check("rst2_width", width, 44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/runner_ctrl.md
Name: runner_ctrl

Overview:
- Parametrised successor of the single-player T-rex character controller.
- Physics constants, position width and ground line are parameters; adds multi-jump (double jump) and clamped landing.
- Sits between input/collision logic and the renderer. Consumes the per-frame `update` tick; produces position, size, state and sprite frame.

Parameters:
- POS_W, 12, signed width of x_pos/y_pos.
- START_X, 20, x position when grounded.
- GROUND_Y, 93, y position when on the ground.
- INIT_VEL, -10, signed launch velocity before speed tweak.
- GRAVITY, 6, gravity accumulator increment per tick.
- GRAV_DEN, 10, accumulator threshold; velocity +1 when reached.
- DROP_VEL, -5, velocity cap applied on early jump release.
- MIN_JUMP_H, 30, height above GROUND_Y before early release may cap velocity.
- SPEED_DROP_VEL, 1, velocity loaded on entering DROPPING.
- DROP_COEF, 3, y-step multiplier while DROPPING.
- MAX_JUMPS, 2, launches allowed per airborne period (1 = classic).
- WIDTH, 44, standing width. WIDTH_DUCK, 59, ducking width. HEIGHT, 47, height.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- update  in  1  one-cycle frame tick; all state changes occur only when high
- timer  in  6  frame counter 0..59
- speed  in  5  game speed
- jump, duck, crash  in  1 each  level inputs
- x_pos, y_pos  out  POS_W signed  top-left position
- width, height  out  10  current sprite size
- state  out  3  WAITING=0 RUNNING=1 JUMPING=2 DROPPING=3 DUCKING=4 CRASHED=5
- frame  out  3  WAITING0..CRASHED0 = 0..7
- jumps_used  out  2  launches in current airborne period

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: state=WAITING, x_pos=START_X, y_pos=GROUND_Y, frame=WAITING0, jumps_used=0. Internals also clear: vel=0 (signed 8b), acc=0 (5b), jump_q=0, min_reached=0.
- When update=0, all registers hold, including frame; crash is ignored.
- jump_rise = jump & ~jump_q. jump_q samples jump on update ticks only.
- Launch: vel <= INIT_VEL - (speed>>3); acc <= 0; min_reached <= 0; jumps_used +1; y unchanged this tick.
- Step (JUMPING/DROPPING):
  - If acc+GRAVITY >= GRAV_DEN: acc -= GRAV_DEN-GRAVITY and nv = vel+1.
  - Otherwise acc += GRAVITY and nv = vel.
  - ny = y + nv*k, with k=1 in JUMPING and k=DROP_COEF in DROPPING.
  - Arithmetic is signed and sign-extended to POS_W+4.
- Per-tick priority is crash > landing > input.
- Transitions:
  - Any state, crash: -> CRASHED. If prior state is DUCKING, x_pos += 1. Position and physics freeze.
  - WAITING: jump_rise -> RUNNING.
  - RUNNING: jump_rise -> JUMPING with launch; else duck -> DUCKING; else hold. Ground values are reasserted each tick.
  - JUMPING, landing (ny >= GROUND_Y): -> RUNNING. y=GROUND_Y (clamped), vel=0, acc=0, jumps_used=0.
  - JUMPING, jump_rise and jumps_used < MAX_JUMPS: relaunch with y=ny. The extra press is ignored when jumps_used == MAX_JUMPS.
  - JUMPING, duck: -> DROPPING with vel=SPEED_DROP_VEL and y=ny.
  - JUMPING, otherwise: y=ny, vel=nv.
  - JUMPING: if duck or ny < GROUND_Y-MIN_JUMP_H, set min_reached. If (!jump or ny < 0) and min_reached and nv < DROP_VEL, then vel=DROP_VEL.
  - DROPPING: landing handled as in JUMPING; !duck -> JUMPING; else step.
  - DUCKING: !duck -> RUNNING.
  - CRASHED: terminal.
- width = WIDTH_DUCK in DUCKING, otherwise WIDTH. height = HEIGHT.
- frame updates on update ticks, from the next state:
  - WAITING: WAITING0 if timer >= 30, else WAITING1.
  - RUNNING: RUNNING0 if timer%10 < 5, else RUNNING1.
  - JUMPING or DROPPING: JUMPING0.
  - DUCKING: DUCKING0 if timer%20 < 10, else DUCKING1.
  - CRASHED: CRASHED0.
- Outputs are registered: one-cycle latency from the update tick.
- Reset asserted mid-jump returns to reset values on the next clock.

Optional Feature:
- Macro: RUNNER_RESTART_EN.
- Defined: in CRASHED, jump_rise on an update tick -> RUNNING. x=START_X, y=GROUND_Y, vel=acc=0, jumps_used=0, frame=RUNNING0/1 per timer. crash takes priority over restart on the same tick.
- Undefined: CRASHED exits only via rst.

Test Plan:
- Reset, then update with jump=1 and timer=40 -> state=RUNNING, frame=RUNNING0, y=93.
- RUNNING, speed=0, jump_rise -> vel=-10, y=93, jumps_used=1. Next two ticks with jump held -> y=83, then y=74 (vel=-9, acc=2).
- Airborne, jumps_used=1: jump released for one tick, then pressed -> vel reset to -10, jumps_used=2. A third press -> ignored, jumps_used stays 2.
- y=90, vel=+5 in JUMPING -> state=RUNNING, y=93 (clamped), jumps_used=0.
- JUMPING at y=60 with duck=1 -> DROPPING, vel=1. Next tick -> vel stays 1 (acc 0->6), y=63.
- crash=1 with update=0 -> no change. Then crash=1 with update=1 while DUCKING at x=20 -> CRASHED, x=21, frame=7. With RUNNER_RESTART_EN, later jump_rise -> RUNNING, x=20.
